banked_ram_ctrl: RTL and testbench

- Parametrised multi-bank synchronous RAM controller. Generalises the fixed 3×512×8 banked wrapper to N banks, any power-of-two bank depth, byte-lane data width and a single clock.
- Adds a post-reset clear sweep, a ready/valid-style read return, byte-enable writes and out-of-range error reporting.
- Sits between the CPU load/store unit or fetch unit and on-chip block RAM.

---
 rtl/banked_ram_ctrl.sv | 111 +++++++++++
 tb/tb_banked_ram_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/banked_ram_ctrl.sv
// rtl/banked_ram_ctrl.sv - N-bank RAM controller with clear sweep, byte-enable writes, 1-cycle reads.
// Optional macro BANKED_RAM_RAW_BYPASS_EN: same-address read/write returns the merged (post-write) word.
module banked_ram_ctrl #(
  parameter int DATA_W    = 32,
  parameter int BANK_AW   = 9,
  parameter int NUM_BANKS = 3,
  parameter int AW        = BANK_AW + ((NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0)
) (
  input  logic                CLK,
  input  logic                RST_N,
  output logic                READY,
  input  logic                RE,
  input  logic [AW-1:0]       RADDR,
  output logic [DATA_W-1:0]   RDATA,
  output logic                RVALID,
  input  logic                WE,
  input  logic [AW-1:0]       WADDR,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WBE,
  output logic                ERR
);

  localparam int LANES  = DATA_W / 8;
  localparam int DEPTH  = 2 ** BANK_AW;
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t               state_q, state_d;
  logic [BANK_AW-1:0]   clr_cnt;
  logic [DATA_W-1:0]    mem [NUM_BANKS][DEPTH];

  logic [BANK_W-1:0]    r_bank, w_bank, r_bank_safe, w_bank_safe;
  logic [BANK_AW-1:0]   r_idx, w_idx;
  logic                 r_oor, w_oor;
  logic                 run;
  logic [DATA_W-1:0]    rd_word;

  assign r_idx = RADDR[BANK_AW-1:0];
  assign w_idx = WADDR[BANK_AW-1:0];

  generate
    if (NUM_BANKS > 1) begin : g_multi
      localparam logic [BANK_W:0] NB = NUM_BANKS[BANK_W:0];
      assign r_bank = RADDR[AW-1:BANK_AW];
      assign w_bank = WADDR[AW-1:BANK_AW];
      assign r_oor  = ({1'b0, r_bank} >= NB);
      assign w_oor  = ({1'b0, w_bank} >= NB);
    end else begin : g_single
      assign r_bank = '0;
      assign w_bank = '0;
      assign r_oor  = 1'b0;
      assign w_oor  = 1'b0;
    end
  endgenerate

  // Clamp so the array is never indexed past its last bank; results are masked anyway.
  assign r_bank_safe = r_oor ? '0 : r_bank;
  assign w_bank_safe = w_oor ? '0 : w_bank;
  assign run         = (state_q == ST_RUN);

  always_comb begin
    rd_word = mem[r_bank_safe][r_idx];
`ifdef BANKED_RAM_RAW_BYPASS_EN
    if (WE && !w_oor && !r_oor && (RADDR == WADDR)) begin
      for (int i = 0; i < LANES; i++) begin
        if (WBE[i]) rd_word[i*8 +: 8] = WDATA[i*8 +: 8];
      end
    end
`endif
    if (r_oor) rd_word = '0;
  end

  always_comb begin
    state_d = state_q;
    READY   = 1'b0;
    case (state_q)
      ST_CLEAR: if (clr_cnt == '1) state_d = ST_RUN;
      ST_RUN:   READY = 1'b1;
      default:  state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_CLEAR;
      clr_cnt <= '0;
      RVALID  <= 1'b0;
      RDATA   <= '0;
      ERR     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_CLEAR) clr_cnt <= clr_cnt + BANK_AW'(1);
      RVALID <= run & RE;
      ERR    <= run & ((RE & r_oor) | (WE & w_oor));
      if (run && RE) RDATA <= rd_word;
    end
  end

  // Storage has no reset; the sweep zeroes one word of every bank per cycle instead.
  always_ff @(posedge CLK) begin
    if (state_q == ST_CLEAR) begin
      for (int b = 0; b < NUM_BANKS; b++) mem[b][clr_cnt] <= '0;
    end else if (WE && !w_oor) begin
      for (int i = 0; i < LANES; i++) begin
        if (WBE[i]) mem[w_bank_safe][w_idx][i*8 +: 8] <= WDATA[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_banked_ram_ctrl.sv
// tb/tb_banked_ram_ctrl.sv - randomized self-checking bench for banked_ram_ctrl against a flat word-array model.
module tb_banked_ram_ctrl;

  localparam int NWORDS = 3 * 512;

  logic        CLK, RST_N, READY, RE, WE, RVALID, ERR;
  logic [10:0] RADDR, WADDR;
  logic [31:0] RDATA, WDATA;
  logic [3:0]  WBE;

  logic [31:0] model [NWORDS];
  logic [31:0] last_rd;
  int          n_tests, n_fail;

  banked_ram_ctrl dut (
    .CLK(CLK), .RST_N(RST_N), .READY(READY), .RE(RE), .RADDR(RADDR),
    .RDATA(RDATA), .RVALID(RVALID), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
    .WBE(WBE), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  // One request cycle: model predicts, DUT edge, then compare returned strobe/data/error.
  task automatic cyc(input logic re, input logic [10:0] ra, input logic we,
                     input logic [10:0] wa, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] rv;
    logic        exp_err;
    RE = re; RADDR = ra; WE = we; WADDR = wa; WDATA = wd; WBE = be;
    exp_err = (re && ra >= NWORDS) || (we && wa >= NWORDS);
    if (re) begin
      rv = (ra < NWORDS) ? model[ra] : 32'h0;
`ifdef BANKED_RAM_RAW_BYPASS_EN
      if (we && wa == ra && ra < NWORDS) rv = merge(rv, wd, be);
`endif
      last_rd = rv;
    end
    if (we && wa < NWORDS) model[wa] = merge(model[wa], wd, be);
    @(posedge CLK); #1;
    check("rvalid", {63'b0, RVALID}, {63'b0, re});
    check("err", {63'b0, ERR}, {63'b0, exp_err});
    check("rdata", {32'b0, RDATA}, {32'b0, last_rd});
    RE = 1'b0; WE = 1'b0;
  endtask

  // Counts CLEAR cycles while hammering requests that must be ignored.
  task automatic wait_clear();
    int n;
    n = 0;
    while (!READY && n < 2000) begin
      RE = 1'b1; RADDR = 11'($urandom_range(0, 2047));
      WE = 1'b1; WADDR = 11'($urandom_range(0, NWORDS - 1));
      WDATA = $urandom; WBE = 4'hF;
      @(posedge CLK); #1;
      n++;
      if (!READY) begin
        check("clear_rvalid", {63'b0, RVALID}, 64'd0);
        check("clear_err", {63'b0, ERR}, 64'd0);
      end
    end
    RE = 1'b0; WE = 1'b0;
    check("clear_len", 64'(n), 64'd512);
    for (int i = 0; i < NWORDS; i++) model[i] = 32'h0;
    last_rd = 32'h0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; last_rd = 32'h0;
    RST_N = 1'b0; RE = 1'b0; WE = 1'b0; RADDR = '0; WADDR = '0; WDATA = '0; WBE = '0;
    #22;
    check("rst_ready", {63'b0, READY}, 64'd0);
    check("rst_rvalid", {63'b0, RVALID}, 64'd0);
    check("rst_rdata", {32'b0, RDATA}, 64'd0);
    check("rst_err", {63'b0, ERR}, 64'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    wait_clear();

    for (int i = 0; i < 8; i++) cyc(1'b1, 11'($urandom_range(0, NWORDS - 1)), 1'b0, '0, '0, '0);

    cyc(1'b0, '0, 1'b1, 11'h205, 32'hDEADBEEF, 4'hF);
    cyc(1'b1, 11'h205, 1'b0, '0, '0, '0);
    check("full_wr", {32'b0, RDATA}, 64'hDEADBEEF);
    cyc(1'b0, '0, 1'b1, 11'h205, 32'h11223344, 4'b0101);
    cyc(1'b1, 11'h205, 1'b0, '0, '0, '0);
    check("part_wr", {32'b0, RDATA}, 64'hDE22BE44);

    cyc(1'b1, 11'h600, 1'b0, '0, '0, '0);
    check("oor_rdata", {32'b0, RDATA}, 64'd0);
    cyc(1'b0, '0, 1'b0, '0, '0, '0);
    cyc(1'b0, '0, 1'b1, 11'h600, 32'hCAFEF00D, 4'hF);
    cyc(1'b1, 11'h000, 1'b0, '0, '0, '0);
    check("oor_wr_drop", {32'b0, RDATA}, 64'd0);
    cyc(1'b1, 11'h600, 1'b1, 11'h7FF, 32'h1, 4'hF);
    cyc(1'b0, '0, 1'b0, '0, '0, '0);

    cyc(1'b0, '0, 1'b1, 11'h010, 32'hAAAAAAAA, 4'hF);
    cyc(1'b1, 11'h010, 1'b1, 11'h010, 32'h55555555, 4'b0011);
`ifdef BANKED_RAM_RAW_BYPASS_EN
    check("raw_same", {32'b0, RDATA}, 64'hAAAA5555);
`else
    check("raw_same", {32'b0, RDATA}, 64'hAAAAAAAA);
`endif
    cyc(1'b1, 11'h010, 1'b0, '0, '0, '0);
    check("raw_after", {32'b0, RDATA}, 64'hAAAA5555);

    for (int i = 0; i < 3000; i++) begin
      logic [10:0] ra, wa;
      ra = 11'($urandom_range(0, 31));
      case ($urandom_range(0, 2))
        0: ra = 11'($urandom_range(0, 2047));
        1: ra = 11'($urandom_range(11'h5F0, 11'h60F));
        default: ;
      endcase
      case ($urandom_range(0, 3))
        0: wa = 11'($urandom_range(0, 2047));
        1: wa = 11'($urandom_range(0, 31));
        2: wa = 11'($urandom_range(11'h5F0, 11'h60F));
        default: wa = ra;
      endcase
      cyc(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom_range(0, 15)));
    end

    RE = 1'b1; RADDR = 11'h205;
    #3;
    RST_N = 1'b0;
    #1;
    check("midrst_ready", {63'b0, READY}, 64'd0);
    check("midrst_rvalid", {63'b0, RVALID}, 64'd0);
    @(posedge CLK); #1;
    check("midrst_lost", {63'b0, RVALID}, 64'd0);
    RE = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    wait_clear();
    for (int i = 0; i < 8; i++) cyc(1'b1, 11'($urandom_range(0, NWORDS - 1)), 1'b0, '0, '0, '0);
    cyc(1'b1, 11'h010, 1'b0, '0, '0, '0);
    check("recleared", {32'b0, RDATA}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
